// File: rtl/matrix_read_sequencer_if.sv
// Bus between the matrix read sequencer, the three-ROM matrix store and the
// downstream MAC/checker that consumes the delayed valid/row-marker stream.
interface matrix_read_sequencer_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                    start;
    logic                    pause;
    logic [2*ADDR_WIDTH-1:0] romA_addrA;
    logic [2*ADDR_WIDTH-1:0] romA_addrB;
    logic [ADDR_WIDTH-1:0]   romB_addrA;
    logic [ADDR_WIDTH-1:0]   romB_addrB;
    logic [ADDR_WIDTH-1:0]   romC_addrA;
    logic [ADDR_WIDTH-1:0]   romC_addrB;
    logic                    busy;
    logic                    done;
    logic                    data_valid;
    logic                    row_start;
    logic                    row_end;
    logic [ADDR_WIDTH-1:0]   row_idx;

    modport master (
        input  start, pause,
        output romA_addrA, romA_addrB, romB_addrA, romB_addrB, romC_addrA, romC_addrB,
        output busy, done, data_valid, row_start, row_end, row_idx
    );

    modport slave (
        output start, pause,
        input  romA_addrA, romA_addrB, romB_addrA, romB_addrB, romC_addrA, romC_addrB,
        input  busy, done, data_valid, row_start, row_end, row_idx
    );
endinterface

// File: rtl/matrix_read_sequencer.sv
// Walks every row of A in 8-element beats, driving all ROM address buses, and
// delays a valid/row-marker tag to line up with the matrix-store read latency.
module matrix_read_sequencer #(
    parameter int ADDR_WIDTH = 7,
    parameter int LATENCY    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    matrix_read_sequencer_if.master bus
);
    localparam int CW = ADDR_WIDTH - 3;
    localparam int AW = 2 * ADDR_WIDTH;
    localparam int BW = ADDR_WIDTH + CW;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic                  vld;
        logic                  first;
        logic                  last;
        logic                  fin;
        logic [ADDR_WIDTH-1:0] row;
    } tag_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [CW-1:0]         chunk_q, chunk_d;
    logic                  issue_q, issue_d;
    logic                  load;
    logic                  last_beat;
    logic [BW-1:0]         beat_nxt;
    logic [AW-1:0]         a_addr_a_q, a_addr_b_q;
    logic [ADDR_WIDTH-1:0] b_addr_a_q, b_addr_b_q, c_addr_q;
    tag_t                  tag_in;
    tag_t                  vld_pipe_q [1:LATENCY];

    // {row, chunk} is the flat beat index, so one increment handles the chunk wrap.
    assign beat_nxt  = {row_q, chunk_q} + BW'(1);
    assign last_beat = (&row_q) & (&chunk_q);

    always_comb begin
        tag_in       = '0;
        tag_in.vld   = issue_q;
        tag_in.first = issue_q & (chunk_q == '0);
        tag_in.last  = issue_q & (&chunk_q);
        tag_in.fin   = issue_q & last_beat;
        tag_in.row   = row_q;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        chunk_d = chunk_q;
        issue_d = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    row_d   = '0;
                    chunk_d = '0;
                    issue_d = 1'b1;
                    load    = 1'b1;
                end
            end
            ISSUE: begin
                if (last_beat) begin
                    state_d = DRAIN;
                end else if (!bus.pause) begin
                    {row_d, chunk_d} = beat_nxt;
                    issue_d          = 1'b1;
                    load             = 1'b1;
                end
            end
            DRAIN: begin
                if (vld_pipe_q[LATENCY].fin) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            chunk_q    <= '0;
            issue_q    <= 1'b0;
            a_addr_a_q <= '0;
            a_addr_b_q <= '0;
            b_addr_a_q <= '0;
            b_addr_b_q <= '0;
            c_addr_q   <= '0;
            for (int i = 1; i <= LATENCY; i++) vld_pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            chunk_q <= chunk_d;
            issue_q <= issue_d;
            if (load) begin
                a_addr_a_q <= {row_d, chunk_d, 3'b000};
                a_addr_b_q <= {row_d, chunk_d, 3'b100};
                b_addr_a_q <= {chunk_d, 3'b000};
                b_addr_b_q <= {chunk_d, 3'b100};
                c_addr_q   <= row_d;
            end
            vld_pipe_q[1] <= tag_in;
            for (int i = 2; i <= LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    assign bus.romA_addrA = a_addr_a_q;
    assign bus.romA_addrB = a_addr_b_q;
    assign bus.romB_addrA = b_addr_a_q;
    assign bus.romB_addrB = b_addr_b_q;
    assign bus.romC_addrA = c_addr_q;
    assign bus.romC_addrB = c_addr_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = vld_pipe_q[LATENCY].fin;
    assign bus.data_valid = vld_pipe_q[LATENCY].vld;
    assign bus.row_start  = vld_pipe_q[LATENCY].first;
    assign bus.row_end    = vld_pipe_q[LATENCY].last;
    assign bus.row_idx    = vld_pipe_q[LATENCY].row;
endmodule
